// File: rtl/w0rm_alu_logic_pipe_if.sv
// rtl/w0rm_alu_logic_pipe_if.sv - operation/result handshake bundle for the logic ALU pipe
interface w0rm_alu_logic_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            opcode;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic [3:0]            result_flags;
    logic [TAG_WIDTH-1:0]  result_tag;
    logic                  illegal_op;

    modport master (
        output in_valid, opcode, data_a, data_b, tag, out_ready,
        input  in_ready, out_valid, result, result_flags, result_tag, illegal_op
    );

    modport slave (
        input  in_valid, opcode, data_a, data_b, tag, out_ready,
        output in_ready, out_valid, result, result_flags, result_tag, illegal_op
    );
endinterface

// File: rtl/w0rm_alu_logic_pipe.sv
// rtl/w0rm_alu_logic_pipe.sv - pipelined logic ALU with valid/ready flow control
// Optional POPCNT/CLZ opcodes enabled by defining W0RM_ALU_LOGIC_BITCOUNT_EN.
module w0rm_alu_logic_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    w0rm_alu_logic_pipe_if.slave  bus
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] res;
        logic [3:0]            flg;
        logic [TAG_WIDTH-1:0]  tg;
        logic                  ill;
    } stage_t;

    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    stage_t              s0;
    stage_t              pipe   [STAGES];
    stage_t              up     [STAGES];
    logic [STAGES-1:0]   st_vld;
    logic [STAGES-1:0]   up_vld;
    logic [STAGES-1:0]   ld;
    logic                ready_acc;
    logic [DATA_WIDTH-1:0] r;
    logic                ok;

`ifdef W0RM_ALU_LOGIC_BITCOUNT_EN
    localparam int CW = $clog2(DATA_WIDTH + 1);
    logic [CW-1:0] pop_cnt;
    logic [CW-1:0] clz_cnt;
    logic          seen_one;

    // Scan from MSB: every one counts for POPCNT, zeros count for CLZ until the first one.
    always_comb begin
        pop_cnt  = '0;
        clz_cnt  = '0;
        seen_one = 1'b0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            pop_cnt = pop_cnt + CW'(bus.data_a[i]);
            if (bus.data_a[i])
                seen_one = 1'b1;
            else if (!seen_one)
                clz_cnt = clz_cnt + CW'(1);
        end
    end
`endif

    always_comb begin
        r  = '0;
        ok = 1'b1;
        case (bus.opcode)
            4'd0:    r = bus.data_a & bus.data_b;
            4'd1:    r = bus.data_a | bus.data_b;
            4'd2:    r = bus.data_a ^ bus.data_b;
            4'd3:    r = ~bus.data_a;
            4'd4:    r = -bus.data_a;
            4'd5:    r = ~(bus.data_a & bus.data_b);
            4'd6:    r = ~(bus.data_a | bus.data_b);
            4'd7:    r = ~(bus.data_a ^ bus.data_b);
            4'd8:    r = bus.data_a & ~bus.data_b;
            4'd9:    r = bus.data_b;
`ifdef W0RM_ALU_LOGIC_BITCOUNT_EN
            4'd10:   r = DATA_WIDTH'(pop_cnt);
            4'd11:   r = DATA_WIDTH'(clz_cnt);
`endif
            default: ok = 1'b0;
        endcase
        s0.res    = ok ? r : '0;
        s0.flg[0] = (s0.res == '0);
        s0.flg[1] = s0.res[DATA_WIDTH-1];
        s0.flg[2] = ok && (bus.opcode == 4'd4) && (bus.data_a == MOST_NEG);
        s0.flg[3] = ok && (bus.opcode == 4'd4) && (bus.data_a == '0);
        s0.tg     = bus.tag;
        s0.ill    = !ok;
    end

    // A stage may load when empty or when everything below it drains this cycle.
    always_comb begin
        ld        = '0;
        ready_acc = bus.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ld[i]     = !st_vld[i] || ready_acc;
            ready_acc = ld[i];
        end
    end

    always_comb begin
        up_vld[0] = bus.in_valid;
        up[0]     = s0;
        for (int i = 1; i < STAGES; i++) begin
            up_vld[i] = st_vld[i-1];
            up[i]     = pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (reset) begin
                st_vld[i] <= 1'b0;
                pipe[i]   <= '0;
            end else if (ld[i]) begin
                st_vld[i] <= up_vld[i];
                if (up_vld[i])
                    pipe[i] <= up[i];
            end
        end
    end

    assign bus.in_ready     = !reset && ld[0];
    assign bus.out_valid    = st_vld[STAGES-1];
    assign bus.result       = pipe[STAGES-1].res;
    assign bus.result_flags = pipe[STAGES-1].flg;
    assign bus.result_tag   = pipe[STAGES-1].tg;
    assign bus.illegal_op   = pipe[STAGES-1].ill;
endmodule

// File: tb/tb_w0rm_alu_logic_pipe.sv
// tb/tb_w0rm_alu_logic_pipe.sv - directed self-checking bench for w0rm_alu_logic_pipe
module tb_w0rm_alu_logic_pipe;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    w0rm_alu_logic_pipe_if #(.DATA_WIDTH(8), .TAG_WIDTH(4)) bus ();

    w0rm_alu_logic_pipe #(.DATA_WIDTH(8), .STAGES(2), .TAG_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] tg);
        bus.in_valid = v;
        bus.opcode   = op;
        bus.data_a   = a;
        bus.data_b   = b;
        bus.tag      = tg;
    endtask

    // One op through an otherwise idle pipe with out_ready high: 2-cycle latency.
    task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] tg, input logic [7:0] exp_res,
                          input logic [3:0] exp_flg, input logic exp_ill);
        @(negedge clk);
        drive(1'b1, op, a, b, tg);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({name, ".early_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({name, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({name, ".result"}, 32'(bus.result), 32'(exp_res));
        check({name, ".flags"}, 32'(bus.result_flags), 32'(exp_flg));
        check({name, ".tag"}, 32'(bus.result_tag), 32'(tg));
        check({name, ".illegal"}, 32'(bus.illegal_op), 32'(exp_ill));
    endtask

    initial begin
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, 4'd0, 8'h00, 8'h00, 4'h0);
        repeat (2) @(negedge clk);
        check("rst.in_ready_low", 32'(bus.in_ready), 32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.result", 32'(bus.result), 32'd0);
        check("rst.flags", 32'(bus.result_flags), 32'd0);
        check("rst.tag", 32'(bus.result_tag), 32'd0);
        check("rst.illegal", 32'(bus.illegal_op), 32'd0);
        reset = 1'b0;
        #1;
        check("rst.in_ready_high", 32'(bus.in_ready), 32'd1);

        run_op("and",   4'd0, 8'hF0, 8'h3C, 4'h5, 8'h30, 4'h0, 1'b0);
        run_op("or",    4'd1, 8'hF0, 8'h0C, 4'h1, 8'hFC, 4'h2, 1'b0);
        run_op("xor",   4'd2, 8'hFF, 8'hFF, 4'h2, 8'h00, 4'h1, 1'b0);
        run_op("not",   4'd3, 8'h0F, 8'h00, 4'h3, 8'hF0, 4'h2, 1'b0);
        run_op("neg80", 4'd4, 8'h80, 8'h00, 4'h4, 8'h80, 4'h6, 1'b0);
        run_op("neg00", 4'd4, 8'h00, 8'h00, 4'h6, 8'h00, 4'h9, 1'b0);
        run_op("neg01", 4'd4, 8'h01, 8'h00, 4'h7, 8'hFF, 4'h2, 1'b0);
        run_op("nand",  4'd5, 8'hF0, 8'h3C, 4'h8, 8'hCF, 4'h2, 1'b0);
        run_op("nor",   4'd6, 8'hF0, 8'h0C, 4'h9, 8'h03, 4'h0, 1'b0);
        run_op("xnor",  4'd7, 8'hAA, 8'h55, 4'hA, 8'h00, 4'h1, 1'b0);
        run_op("andn",  4'd8, 8'hF0, 8'h3C, 4'hB, 8'hC0, 4'h2, 1'b0);
        run_op("passb", 4'd9, 8'h12, 8'h7E, 4'hD, 8'h7E, 4'h0, 1'b0);
        run_op("ill_f", 4'hF, 8'hAA, 8'h55, 4'hC, 8'h00, 4'h1, 1'b1);
`ifdef W0RM_ALU_LOGIC_BITCOUNT_EN
        run_op("popcnt", 4'd10, 8'hB7, 8'h00, 4'h1, 8'h06, 4'h0, 1'b0);
        run_op("clz10",  4'd11, 8'h10, 8'h00, 4'h2, 8'h03, 4'h0, 1'b0);
        run_op("clz00",  4'd11, 8'h00, 8'h00, 4'h3, 8'h08, 4'h0, 1'b0);
`else
        run_op("ill_10", 4'd10, 8'hB7, 8'h00, 4'h1, 8'h00, 4'h1, 1'b1);
        run_op("ill_11", 4'd11, 8'h10, 8'h00, 4'h2, 8'h00, 4'h1, 1'b1);
`endif

        // Backpressure: two ops fill the pipe, third stalls, then drains in order.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd9, 8'h00, 8'h11, 4'h1);
        check("bp.rdy1", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b1, 4'd9, 8'h00, 8'h22, 4'h2);
        check("bp.rdy2", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b1, 4'd9, 8'h00, 8'h33, 4'h3);
        check("bp.rdy3_low", 32'(bus.in_ready), 32'd0);
        check("bp.valid", 32'(bus.out_valid), 32'd1);
        check("bp.tag_hold0", 32'(bus.result_tag), 32'd1);
        @(negedge clk);
        check("bp.rdy3_still_low", 32'(bus.in_ready), 32'd0);
        check("bp.tag_hold1", 32'(bus.result_tag), 32'd1);
        check("bp.res_hold1", 32'(bus.result), 32'h11);
        bus.out_ready = 1'b1;
        #1;
        check("bp.full_accept", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("bp.tag2", 32'(bus.result_tag), 32'd2);
        check("bp.res2", 32'(bus.result), 32'h22);
        drive(1'b1, 4'd9, 8'h00, 8'h44, 4'h4);
        @(negedge clk);
        check("bp.tag3", 32'(bus.result_tag), 32'd3);
        check("bp.v3", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp.tag4", 32'(bus.result_tag), 32'd4);
        check("bp.res4", 32'(bus.result), 32'h44);
        check("bp.v4", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("bp.drained", 32'(bus.out_valid), 32'd0);

        // Reset with two ops in flight flushes both.
        bus.out_ready = 1'b0;
        drive(1'b1, 4'd9, 8'h00, 8'hAA, 4'hA);
        @(negedge clk);
        drive(1'b1, 4'd9, 8'h00, 8'hBB, 4'hB);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("flush.full", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("flush.rdy_in_reset", 32'(bus.in_ready), 32'd0);
        check("flush.valid", 32'(bus.out_valid), 32'd0);
        check("flush.result", 32'(bus.result), 32'd0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("flush.rdy_after", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("flush.no_ghost", 32'(bus.out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
